// File: rtl/oric_ram_init.sv
// Oric RAM clear sequencer: on reset or clr_req it sweeps every RAM address with a clear
// byte while holding the core in reset, then passes core accesses through. Macro: ORIC_RAM_PATTERN_EN.
module oric_ram_init #(
    parameter int         AW   = 16,
    parameter logic [7:0] FILL = 8'h01
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          clr_req,
    input  logic [15:0]   ram_ad,
    input  logic [7:0]    ram_d,
    input  logic          ram_cs,
    input  logic          ram_we,
    output logic [AW-1:0] mem_a,
    output logic [7:0]    mem_d,
    output logic          mem_ce,
    output logic          mem_we,
    output logic          core_reset,
    output logic          busy,
    output logic          done
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] CNT_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_reg;
    logic [AW-1:0] cnt_reg;
    logic [7:0]    fill_byte;
    logic          last_addr;
    logic          unused_ad;

    assign last_addr = &cnt_reg;
    // Upper core address bits fall outside the RAM and are deliberately dropped.
    assign unused_ad = ^ram_ad;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_fill
`ifdef ORIC_RAM_PATTERN_EN
            // Power-on image: alternating 64-byte blocks of 00 and FF.
            assign fill_byte[gi] = cnt_reg[6];
`else
            assign fill_byte[gi] = FILL[gi];
`endif
        end
    endgenerate

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg  <= ST_CLEAR;
            cnt_reg    <= '0;
            mem_a      <= '0;
            mem_d      <= '0;
            mem_ce     <= 1'b0;
            mem_we     <= 1'b0;
            core_reset <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    mem_a      <= cnt_reg;
                    mem_d      <= fill_byte;
                    mem_ce     <= 1'b1;
                    mem_we     <= 1'b1;
                    core_reset <= 1'b1;
                    busy       <= 1'b1;
                    if (clr_req) begin
                        cnt_reg <= '0;
                        done    <= 1'b0;
                    end else if (last_addr) begin
                        done      <= 1'b1;
                        state_reg <= ST_RUN;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    mem_a      <= ram_ad[AW-1:0];
                    mem_d      <= ram_d;
                    mem_ce     <= ram_cs;
                    mem_we     <= ram_we;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    // busy is still high on the first RUN cycle, stretching core reset by one.
                    core_reset <= busy;
                    if (clr_req) begin
                        state_reg <= ST_CLEAR;
                        cnt_reg   <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oric_ram_init.sv
// Randomized bench for oric_ram_init with a cycle-level behavioural model and a shadow RAM.
module tb_oric_ram_init;
    localparam int         AW   = 10;
    localparam int         SIZE = 1 << AW;
    localparam int         LAST = SIZE - 1;
    localparam logic [7:0] FILL = 8'h01;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          clr_req;
    logic [15:0]   ram_ad;
    logic [7:0]    ram_d;
    logic          ram_cs;
    logic          ram_we;
    logic [AW-1:0] mem_a;
    logic [7:0]    mem_d;
    logic          mem_ce;
    logic          mem_we;
    logic          core_reset;
    logic          busy;
    logic          done;

    always #5 clk_sys = ~clk_sys;

    oric_ram_init #(.AW(AW), .FILL(FILL)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .clr_req    (clr_req),
        .ram_ad     (ram_ad),
        .ram_d      (ram_d),
        .ram_cs     (ram_cs),
        .ram_we     (ram_we),
        .mem_a      (mem_a),
        .mem_d      (mem_d),
        .mem_ce     (mem_ce),
        .mem_we     (mem_we),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done)
    );

    int total = 0;
    int bad   = 0;

    // Model state: are we sweeping, which address comes next, cycles spent in RUN.
    bit         m_clear    = 1'b1;
    int         m_addr     = 0;
    int         m_run_age  = 0;
    int         done_seen  = 0;
    logic [7:0] shadow [SIZE];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fill_of(input int a);
`ifdef ORIC_RAM_PATTERN_EN
        return (((a >> 6) & 1) != 0) ? 8'hFF : 8'h00;
`else
        return FILL;
`endif
    endfunction

    task automatic step(input logic r, input logic clr, input logic [15:0] ad,
                        input logic [7:0] d, input logic cs, input logic we);
        logic [31:0] e_a;
        logic [7:0]  e_d;
        logic        e_ce, e_we, e_done, e_busy, e_cr;
        reset   = r;
        clr_req = clr;
        ram_ad  = ad;
        ram_d   = d;
        ram_cs  = cs;
        ram_we  = we;
        @(posedge clk_sys);
        #1;
        if (r) begin
            e_a = 0; e_d = 8'h00; e_ce = 1'b0; e_we = 1'b0;
            e_done = 1'b0; e_busy = 1'b1; e_cr = 1'b1;
            m_clear = 1'b1;
            m_addr  = 0;
        end else if (m_clear) begin
            e_a = m_addr; e_d = fill_of(m_addr); e_ce = 1'b1; e_we = 1'b1;
            e_busy = 1'b1; e_cr = 1'b1;
            e_done = (m_addr == LAST) && !clr;
            if (clr) m_addr = 0;
            else if (m_addr == LAST) begin
                m_clear   = 1'b0;
                m_run_age = 0;
            end else m_addr = m_addr + 1;
        end else begin
            e_a = int'(ad) % SIZE; e_d = d; e_ce = cs; e_we = we;
            e_busy = 1'b0; e_done = 1'b0;
            e_cr = (m_run_age == 0);
            m_run_age = m_run_age + 1;
            if (clr) begin
                m_clear = 1'b1;
                m_addr  = 0;
            end
        end
        check_val("mem_a", mem_a, e_a);
        check_val("mem_d", mem_d, e_d);
        check_val("mem_ce", mem_ce, e_ce);
        check_val("mem_we", mem_we, e_we);
        check_val("done", done, e_done);
        check_val("busy", busy, e_busy);
        check_val("core_reset", core_reset, e_cr);
        if (done === 1'b1) done_seen++;
        if (mem_ce === 1'b1 && mem_we === 1'b1) shadow[mem_a] = mem_d;
    endtask

    task automatic rstep(input logic clr);
        step(1'b0, clr, 16'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int errs;
        for (int i = 0; i < SIZE; i++) shadow[i] = 8'hXX;

        // Reset wins over a simultaneous clear request.
        step(1'b1, 1'b1, 16'hFFFF, 8'hFF, 1'b1, 1'b1);
        check_val("rst_mem_ce", mem_ce, 1'b0);
        check_val("rst_core_reset", core_reset, 1'b1);

        // Full sweep; a core write to 0x0040 mid-sweep must not land.
        done_seen = 0;
        for (int i = 0; i < SIZE; i++) begin
            if (i == 100) step(1'b0, 1'b0, 16'h0040, 8'h55, 1'b1, 1'b1);
            else rstep(1'b0);
            if (i == 0) check_val("first_addr", mem_a, 0);
        end
        check_val("pass1_done_count", done_seen, 1);
        check_val("pass1_last_addr", mem_a, LAST);
        errs = 0;
        for (int i = 0; i < SIZE; i++) if (shadow[i] !== fill_of(i)) errs++;
        check_val("pass1_ram_errs", errs, 0);
        check_val("ram_0040", shadow[16'h0040], fill_of(16'h0040));
        check_val("ram_003f", shadow[16'h003F], fill_of(16'h003F));
        check_val("ram_0080", shadow[16'h0080], fill_of(16'h0080));

        // First RUN cycle keeps core reset high, then it drops.
        step(1'b0, 1'b0, 16'h1234, 8'hA5, 1'b1, 1'b1);
        check_val("run1_busy", busy, 1'b0);
        check_val("run1_core_reset", core_reset, 1'b1);
        check_val("pass_a", mem_a, 10'h234);
        check_val("pass_d", mem_d, 8'hA5);
        step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
        check_val("pass_ce_off", mem_ce, 1'b0);
        check_val("run2_core_reset", core_reset, 1'b0);
        for (int i = 0; i < 50; i++) rstep(1'b0);

        // Clear from RUN, then abort the sweep at address 300.
        rstep(1'b1);
        for (int i = 0; i < 300; i++) rstep(1'b0);
        done_seen = 0;
        rstep(1'b1);
        check_val("abort_addr", mem_a, 300);
        rstep(1'b0);
        check_val("restart_addr", mem_a, 0);
        for (int i = 1; i < SIZE; i++) rstep(1'b0);
        check_val("abort_done_count", done_seen, 1);

        // Held clear request keeps rewriting address 0.
        rstep(1'b1);
        for (int i = 0; i < 5; i++) begin
            rstep(1'b1);
            check_val("held_addr", mem_a, 0);
            check_val("held_core_reset", core_reset, 1'b1);
        end
        done_seen = 0;
        for (int i = 0; i < LAST; i++) rstep(1'b0);
        rstep(1'b1);
        check_val("lastclr_addr", mem_a, LAST);
        check_val("lastclr_done", done, 1'b0);
        rstep(1'b0);
        check_val("lastclr_next_addr", mem_a, 0);
        check_val("lastclr_busy", busy, 1'b1);
        for (int i = 1; i < SIZE; i++) rstep(1'b0);
        check_val("lastclr_done_count", done_seen, 1);

        // Random traffic with sparse clear requests and resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0)
                step(1'b1, 1'($urandom), 16'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            else
                rstep($urandom_range(0, 499) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
